// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//
// Lets up to NUM_REQ pixel-pipeline requesters share one single-port sprite/tile ROM.
// The requesters are the background tile fetch, the player, enemies, bombs and so on.
// A winner is picked in IDLE and its access is issued in the one-cycle ISSUE state.
// This gives at most one ROM access every two clk cycles, i.e. one per 25 MHz pixel tick.
// Each response comes back ROM_LAT cycles after its rom_en cycle.
// It is tagged with a one-hot rvalid that names the requester who asked for it.
//
// Optional build macro:
//   SPRITE_ARB_BG_PRIO_EN - requester 0 (background fetch) has strict priority and does not
//                           move the round-robin pointer; the others rotate among themselves.
//                           Undefined: pure round-robin over all requesters.
//
// Ports:
//   clk       in   system clock (50 MHz)
//   reset     in   asynchronous active-high reset
//   req       in   [NUM_REQ]         level requests, held until granted
//   req_addr  in   [NUM_REQ*ADDR_W]  requester i address at [i*ADDR_W +: ADDR_W]
//   gnt       out  [NUM_REQ]         one-hot single-cycle grant pulse
//   rom_en    out                    ROM read enable
//   rom_addr  out  [ADDR_W]          ROM read address
//   rom_data  in   [DATA_W]          ROM read data, valid ROM_LAT cycles after rom_en
//   rvalid    out  [NUM_REQ]         one-hot single-cycle response-valid pulse
//   rdata     out  [DATA_W]          response data (rom_data), qualified by rvalid
//   busy      out                    an access is being issued or is still in flight

module sprite_rom_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned ROM_LAT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {StIdle, StIssue} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    // Response pipeline: a valid bit plus the requester index per stage.
    logic [ROM_LAT-1:0] pv_q, pv_d;
    logic [IDX_W-1:0]   pidx_q [ROM_LAT];
    logic [IDX_W-1:0]   pidx_d [ROM_LAT];

    logic               issue;
    logic [NUM_REQ-1:0] cand_req;
    logic [31:0]        cand;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [IDX_W-1:0]   ptr_next;

    assign issue = (state_q == StIssue);

    // ------------------------------------------------------------------
    // Winner selection: first set request scanning upward from the pointer.
    // The index is wrapped at NUM_REQ explicitly so non-power-of-2 counts work.
    // ------------------------------------------------------------------
    always_comb begin
        cand_req  = req;
`ifdef SPRITE_ARB_BG_PRIO_EN
        // Requester 0 is handled by the priority override below, not by the rotation.
        cand_req[0] = 1'b0;
`endif
        cand      = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_addr  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!sel_found && cand_req[cand[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
                sel_addr  = req_addr[cand*ADDR_W +: ADDR_W];
            end
        end
`ifdef SPRITE_ARB_BG_PRIO_EN
        if (req[0]) begin
            sel_found = 1'b1;
            sel_idx   = '0;
            sel_addr  = req_addr[ADDR_W-1:0];
        end
`endif
    end

    assign ptr_next = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                // Requests and addresses are only sampled here.
                if (sel_found) begin
                    win_d   = sel_idx;
                    addr_d  = sel_addr;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StIdle;
                ptr_d   = ptr_next;
`ifdef SPRITE_ARB_BG_PRIO_EN
                if (win_q == '0) begin
                    ptr_d = ptr_q;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Response pipeline next state
    // ------------------------------------------------------------------
    always_comb begin
        pv_d      = '0;
        pv_d[0]   = issue;
        pidx_d[0] = win_q;
        for (int unsigned s = 1; s < ROM_LAT; s++) begin
            pv_d[s]   = pv_q[s-1];
            pidx_d[s] = pidx_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            win_q   <= '0;
            addr_q  <= '0;
            pv_q    <= '0;
            for (int unsigned s = 0; s < ROM_LAT; s++) begin
                pidx_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            pv_q    <= pv_d;
            for (int unsigned s = 0; s < ROM_LAT; s++) begin
                pidx_q[s] <= pidx_d[s];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. They decode registered state only, so reset clears them at once.
    // ------------------------------------------------------------------
    always_comb begin
        gnt    = '0;
        rvalid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            gnt[i]    = issue && (win_q == IDX_W'(i));
            rvalid[i] = pv_q[ROM_LAT-1] && (pidx_q[ROM_LAT-1] == IDX_W'(i));
        end
    end

    assign rom_en   = issue;
    assign rom_addr = issue ? addr_q : '0;
    assign rdata    = rom_data;
    assign busy     = issue | (|pv_q);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [55:0] req_addr;
    logic [3:0]  gnt;
    logic        rom_en;
    logic [13:0] rom_addr;
    logic [11:0] rom_data;
    logic [3:0]  rvalid;
    logic [11:0] rdata;
    logic        busy;

    sprite_rom_arbiter #(
        .NUM_REQ (4),
        .ADDR_W  (14),
        .DATA_W  (12),
        .ROM_LAT (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    // Fixed per-requester addresses and the data the ROM model returns for them.
    logic [13:0] exp_addr [4] = '{14'h0100, 14'h0211, 14'h0123, 14'h0333};
    logic [11:0] exp_data [4] = '{12'h4A5, 12'h7B4, 12'hABC, 12'h696};

    // ROM model: two-cycle registered read.
    logic [13:0] r1, r2;
    function automatic logic [11:0] rom_word(input logic [13:0] a);
        if (a == 14'h0123) return 12'hABC;
        return a[11:0] ^ 12'h5A5;
    endfunction
    always @(posedge clk) begin
        r1 <= rom_addr;
        r2 <= r1;
    end
    assign rom_data = rom_word(r2);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    typedef struct {
        int          idx;
        logic [13:0] addr;
        int          gap;   // required cycles since the previous grant, 0 = unchecked
    } gnt_t;
    typedef struct {
        int          idx;
        logic [11:0] data;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];
    int   en_q[$];

    task automatic expect_gnt(input int idx, input int gap, input bit rsp);
        gnt_t g;
        rsp_t r;
        g.idx  = idx;
        g.addr = exp_addr[idx];
        g.gap  = gap;
        gq.push_back(g);
        if (rsp) begin
            r.idx  = idx;
            r.data = exp_data[idx];
            rq.push_back(r);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant or a response.
    gnt_t       m_g;
    rsp_t       m_r;
    int         m_en;
    int         last_gnt_cyc = 0;
    logic [3:0] m_oh;
    always @(negedge clk) begin
        if (reset) begin
            en_q.delete();
        end else begin
            if (rom_en) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", {60'd0, gnt}, 64'd0);
                end else begin
                    m_g  = gq.pop_front();
                    m_oh = 4'b0001 << m_g.idx;
                    chk("gnt", {60'd0, gnt}, {60'd0, m_oh});
                    chk("rom_addr", {50'd0, rom_addr}, {50'd0, m_g.addr});
                    if (m_g.gap != 0) chk("gnt_gap", 64'(cyc - last_gnt_cyc), 64'(m_g.gap));
                end
                last_gnt_cyc = cyc;
                en_q.push_back(cyc);
            end else if (gnt != 4'b0) begin
                chk("gnt_without_rom_en", {60'd0, gnt}, 64'd0);
            end
            if (rvalid != 4'b0) begin
                if (rq.size() == 0) begin
                    chk("rvalid_unexpected", {60'd0, rvalid}, 64'd0);
                end else begin
                    m_r  = rq.pop_front();
                    m_oh = 4'b0001 << m_r.idx;
                    chk("rvalid", {60'd0, rvalid}, {60'd0, m_oh});
                    chk("rdata", {52'd0, rdata}, {52'd0, m_r.data});
                    if (en_q.size() != 0) begin
                        m_en = en_q.pop_front();
                        chk("rvalid_latency", 64'(cyc - m_en), 64'd2);
                    end else begin
                        chk("rvalid_no_issue", {60'd0, rvalid}, 64'd0);
                    end
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        req      = 4'b0;
        req_addr = {exp_addr[3], exp_addr[2], exp_addr[1], exp_addr[0]};
        repeat (3) @(negedge clk);
        chk("reset_outputs", {31'd0, gnt, rom_en, rom_addr, rvalid, busy}, 64'd0);
        reset = 1'b0;

        // Idle: nothing may move for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outputs", {31'd0, gnt, rom_en, rom_addr, rvalid, busy}, 64'd0);
        end

        // Full contention: 8 grants, two cycles apart.
        for (int i = 0; i < 8; i++) begin
`ifdef SPRITE_ARB_BG_PRIO_EN
            expect_gnt(0, (i == 0) ? 0 : 2, 1'b1);
`else
            expect_gnt(i % 4, (i == 0) ? 0 : 2, 1'b1);
`endif
        end
        req = 4'hF;
        repeat (16) @(negedge clk);
        req = 4'b0;
        repeat (6) @(negedge clk);
        chk("busy_after_contention", {63'd0, busy}, 64'd0);

        // Single request: grant one cycle after req, response two cycles after rom_en.
        expect_gnt(2, 0, 1'b1);
        req = 4'b0100;
        @(negedge clk);
        chk("single_gnt_latency", {60'd0, gnt}, 64'h4);
        req = 4'b0;
        repeat (5) @(negedge clk);

        // Wrap-around: pointer sits at 3 after granting 2.
`ifdef SPRITE_ARB_BG_PRIO_EN
        expect_gnt(0, 0, 1'b1);
        expect_gnt(0, 2, 1'b1);
`else
        expect_gnt(3, 0, 1'b1);
        expect_gnt(0, 2, 1'b1);
`endif
        req = 4'b1001;
        repeat (3) @(negedge clk);
        req = 4'b0;
        repeat (6) @(negedge clk);

        // Reset in the cycle after rom_en: the aborted access must never respond.
        expect_gnt(1, 0, 1'b0);
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("reset_flush", {55'd0, rvalid, gnt, rom_en}, 64'd0);
            if (i == 1) reset = 1'b0;
        end
        expect_gnt(0, 0, 1'b1);
        req = 4'hF;
        @(negedge clk);
        req = 4'b0;
        repeat (6) @(negedge clk);

`ifdef SPRITE_ARB_BG_PRIO_EN
        // Background priority: requester 0 wins every slot, then the rest rotate.
        for (int i = 0; i < 4; i++) expect_gnt(0, (i == 0) ? 0 : 2, 1'b1);
        expect_gnt(1, 2, 1'b1);
        expect_gnt(2, 2, 1'b1);
        expect_gnt(3, 2, 1'b1);
        expect_gnt(1, 2, 1'b1);
        req = 4'hF;
        repeat (7) @(negedge clk);
        req = 4'hE;
        repeat (8) @(negedge clk);
        req = 4'b0;
        repeat (6) @(negedge clk);
`endif

        chk("grants_outstanding", 64'(gq.size()), 64'd0);
        chk("responses_outstanding", 64'(rq.size()), 64'd0);
        chk("busy_final", {63'd0, busy}, 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
